// File: rtl/parity_pkg.sv
// Shared parity encodings and sizing helper for the parity stream unit.
package parity_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  // Index width for a counter spanning n values; never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational XOR reduction of a data word with odd/even selection.
module parity_calc #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd_sel,
  output logic              raw_c,
  output logic              par_c
);

  assign raw_c = ^data;
  assign par_c = raw_c ^ odd_sel;

endmodule

// File: rtl/parity_stream_unit.sv
// Registered parity generator/checker on a valid/ready stream with per-block
// parity and a saturating error counter.
module parity_stream_unit
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BLOCK_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              check_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              out_last,
  output logic              out_blk_par,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned IDX_W = idx_width(BLOCK_LEN);

  logic              out_valid_q,   out_valid_d;
  logic [DATA_W-1:0] out_data_q,    out_data_d;
  logic              out_par_q,     out_par_d;
  logic              out_err_q,     out_err_d;
  logic              out_last_q,    out_last_d;
  logic              out_blk_par_q, out_blk_par_d;
  logic [CNT_W-1:0]  err_cnt_q,     err_cnt_d;
  logic [IDX_W-1:0]  word_idx_q,    word_idx_d;
  logic              acc_q,         acc_d;

  logic odd_sel;
  logic raw_par;
  logic word_par;
  logic accept;
  logic is_last;
  logic err_now;

  assign odd_sel = (odd_mode == PAR_ODD);

  parity_calc #(.DATA_W(DATA_W)) u_calc (
    .data    (in_data),
    .odd_sel (odd_sel),
    .raw_c   (raw_par),
    .par_c   (word_par)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_last  = (word_idx_q == IDX_W'(BLOCK_LEN - 1));
  assign err_now  = (check_mode == MODE_CHK) && ((raw_par ^ in_par) != odd_sel);

  // Output slice, block tracking and error counter next-state.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_par_d     = out_par_q;
    out_err_d     = out_err_q;
    out_last_d    = out_last_q;
    out_blk_par_d = out_blk_par_q;
    err_cnt_d     = err_cnt_q;
    word_idx_d    = word_idx_q;
    acc_d         = acc_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_par_d   = (check_mode == MODE_CHK) ? in_par : word_par;
      out_err_d   = err_now;
      out_last_d  = is_last;
      if (is_last) begin
        out_blk_par_d = acc_q ^ word_par;
        acc_d         = 1'b0;
        word_idx_d    = '0;
      end else begin
        out_blk_par_d = 1'b0;
        acc_d         = acc_q ^ raw_par;
        word_idx_d    = word_idx_q + IDX_W'(1);
      end
    end

    // Clear wins over a coincident erroring accept.
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (accept && err_now && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_par_q     <= 1'b0;
      out_err_q     <= 1'b0;
      out_last_q    <= 1'b0;
      out_blk_par_q <= 1'b0;
      err_cnt_q     <= '0;
      word_idx_q    <= '0;
      acc_q         <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_par_q     <= out_par_d;
      out_err_q     <= out_err_d;
      out_last_q    <= out_last_d;
      out_blk_par_q <= out_blk_par_d;
      err_cnt_q     <= err_cnt_d;
      word_idx_q    <= word_idx_d;
      acc_q         <= acc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_par     = out_par_q;
  assign out_err     = out_err_q;
  assign out_last    = out_last_q;
  assign out_blk_par = out_blk_par_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: doc/parity_stream_unit.md
# parity_stream_unit

Parametrised, registered parity generator/checker for a valid/ready word stream, the sequential successor of the fixed 4-bit combinational parity encoder. Generate mode appends a per-word parity bit. Check mode compares the incoming parity bit and counts errors. Both modes also produce a per-block parity over every BLOCK_LEN words. The block sits between a word source and a link or storage stage, with one register slice that honours backpressure.

## Interface
- DATA_W, 8, data word width (≥1)
- BLOCK_LEN, 4, words per block (≥1)
- CNT_W, 8, error counter width (≥1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on accept
- check_mode  input  1  0 = generate, 1 = check; sampled on accept
- in_valid  input  1  source word valid
- in_ready  output  1  unit can accept a word
- in_data  input  DATA_W  source word
- in_par  input  1  received parity bit (check mode only)
- out_valid  output  1  output word valid
- out_ready  input  1  sink accepts output word
- out_data  output  DATA_W  registered word
- out_par  output  1  generated parity (gen) or passed-through in_par (check)
- out_err  output  1  parity mismatch on this word (check mode only, else 0)
- out_last  output  1  word is the last of its block
- out_blk_par  output  1  block parity; meaningful only when out_last=1, else 0
- clr_cnt  input  1  synchronous clear of err_cnt
- err_cnt  output  CNT_W  saturating count of accepted words with out_err=1

## Operation
- Accept happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- in_ready = !out_valid || out_ready, which is combinational.
- Word parity wp = ^in_data ^ odd_mode.
- On accept:
  - out_data <= in_data.
  - Generate mode: out_par <= wp, out_err <= 0.
  - Check mode: out_par <= in_par, out_err <= (^in_data ^ in_par) != odd_mode.
- Block tracking:
  - word_idx runs 0..BLOCK_LEN-1 and increments on accept, wrapping to 0 after BLOCK_LEN-1.
  - out_last <= (word_idx == BLOCK_LEN-1). When BLOCK_LEN=1, every word is last.
  - Raw accumulator acc holds the XOR of all data bits of the block's earlier accepted words.
  - On the last word: out_blk_par <= acc ^ ^in_data ^ odd_mode, and acc <= 0. Otherwise acc <= acc ^ ^in_data.
- odd_mode and check_mode may change between any two words. Each word uses the values sampled at its own accept. out_blk_par uses the odd_mode value of the last word.
- err_cnt:
  - Increments by 1 on an accept that sets out_err=1.
  - Holds at all-ones.
  - clr_cnt has priority: if clr_cnt and an erroring accept occur in the same cycle, err_cnt becomes 0.
- If out_valid && !out_ready, all out_* signals hold stable and no accept occurs.
- If out_valid && out_ready && !in_valid, out_valid falls to 0 and the other out_* signals hold their last values.

## Timing
- Latency is 1 cycle from accept to out_valid. Throughput is 1 word/cycle while out_ready=1.
- Reset values: out_valid=0, out_data=0, out_par=0, out_err=0, out_last=0, out_blk_par=0, err_cnt=0, word_idx=0, acc=0. in_ready=1 from the first cycle after reset.
- Reset asserted mid-block discards the held word and the partial block. The next accepted word is index 0.
- Simultaneous output transfer and accept: the new word is loaded in that same cycle and out_valid stays 1, so there is no bubble.
- No state machine beyond the valid/idle slice. All state is held in word_idx, acc and err_cnt.

## Structure
- Shared package parity_pkg holds:
  - localparams PAR_EVEN=1'b0 and PAR_ODD=1'b1, MODE_GEN=1'b0 and MODE_CHK=1'b1;
  - function for $clog2-based index width (minimum 1).
- One sub-module, parity_calc: a combinational XOR reduction of DATA_W bits with an odd-select input. It is instantiated once for wp; the check-mode and block terms reuse its raw output.

## Test plan
DATA_W=8, BLOCK_LEN=4 unless noted.
- **Generate, even:** in_data 0x07, then 0x03, back-to-back with out_ready=1 → out_par 1 then 0. Each word appears one cycle after accept, and out_valid stays continuously high.
- **Generate, odd:** 0x00 → out_par 1. 0xFF → out_par 1. out_err stays 0.
- **Check, even:**
  - 0x01 with in_par=0 → out_err=1, err_cnt=1.
  - 0x01 with in_par=1 → out_err=0, err_cnt stays 1.
  - Switching to odd_mode, 0x01 with in_par=0 → out_err=0.
- **Blocks:**
  - 0x01, 0x02, 0x04, 0x08 (even) → out_last only on 0x08, out_blk_par=0.
  - The next block 0x01, 0x00, 0x00, 0x00 → out_blk_par=1.
  - A fifth word is word_idx 0.
- **Backpressure:** hold out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 → in_ready=0, out_* stable, word_idx unchanged. Release → both words delivered in order, none dropped or duplicated.
- **Saturation, clear, reset:**
  - CNT_W=2, 5 erroring words → err_cnt=3.
  - clr_cnt coincident with an erroring accept → err_cnt=0.
  - rst_n pulsed low after 2 words of a block → all outputs at reset values, and the next 4 words give out_last on the 4th.
